// File: rtl/motor_slot_timer_if.sv
// Handshake bundle for motor_slot_timer.
// Master drives En/Div; slave returns the slot timing outputs.
interface motor_slot_timer_if #(
  parameter int CH_NUM = 8,
  parameter int PH_NUM = 2,
  parameter int DIV_W  = 16
);
  logic              En;
  logic [DIV_W-1:0]  Div;
  logic [DIV_W-1:0]  Div_act;
  logic [CH_NUM-1:0] Slot_1h;
  logic [CH_NUM-1:0] Slot_pls;
  logic              Frame_pls;
  logic [PH_NUM-1:0] Ph_out;

  modport master (
    output En, Div,
    input  Div_act, Slot_1h, Slot_pls, Frame_pls, Ph_out
  );

  modport slave (
    input  En, Div,
    output Div_act, Slot_1h, Slot_pls, Frame_pls, Ph_out
  );
endinterface

// File: rtl/motor_slot_timer.sv
// Programmable slot/frame/phase timer for time-multiplexed motor channels.
// Optional SLOT_GUARD_EN: one dead Slot_1h/Ph_out cycle at each slot end.
module motor_slot_timer #(
  parameter int CH_NUM = 8,
  parameter int PH_NUM = 2,
  parameter int DIV_W  = 16
) (
  input logic gClk,
  input logic Rst_n,
  motor_slot_timer_if.slave bus
);
  localparam int SW    = $clog2(CH_NUM);
  localparam int GROUP = CH_NUM / PH_NUM;
  localparam logic [SW-1:0] LAST = SW'(CH_NUM - 1);

  logic              run_q, run_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [DIV_W-1:0]  div_act_q, div_act_d;
  logic [CH_NUM-1:0] slot_1h_q, slot_1h_d;
  logic [CH_NUM-1:0] slot_pls_q, slot_pls_d;
  logic              frame_pls_q, frame_pls_d;
  logic [PH_NUM-1:0] ph_q, ph_d;
  logic              tick;
  logic              new_slot;

  always_comb begin
    run_d     = run_q;
    presc_d   = presc_q;
    slot_d    = slot_q;
    div_act_d = div_act_q;
    new_slot  = 1'b0;
    tick      = (presc_q == div_act_q);
    unique case (1'b1)
      !bus.En: begin
        run_d     = 1'b0;
        presc_d   = '0;
        slot_d    = '0;
        div_act_d = bus.Div;
      end
      bus.En && !run_q: begin
        run_d     = 1'b1;
        presc_d   = '0;
        slot_d    = '0;
        div_act_d = bus.Div;
        new_slot  = 1'b1;
      end
      bus.En && run_q && tick: begin
        presc_d  = '0;
        new_slot = 1'b1;
        if (slot_q == LAST) begin
          slot_d    = '0;
          div_act_d = bus.Div;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      default: presc_d = presc_q + 1'b1;
    endcase
  end

  // Outputs are registered from next state so they line up with the slot.
  always_comb begin
    slot_1h_d  = '0;
    slot_pls_d = '0;
    ph_d       = '0;
    if (run_d) begin
      slot_1h_d = CH_NUM'(1) << slot_d;
      if (new_slot) slot_pls_d = slot_1h_d;
      for (int k = 0; k < PH_NUM; k++) begin
        ph_d[k] = (int'(slot_d) >= k * GROUP + GROUP / 2) &&
                  (int'(slot_d) <= (k + 1) * GROUP - 1);
      end
`ifdef SLOT_GUARD_EN
      if (div_act_d != '0 && presc_d == div_act_d) begin
        slot_1h_d = '0;
        ph_d      = '0;
      end
`else
`endif
    end
    frame_pls_d = slot_pls_d[0];
  end

  always_ff @(posedge gClk or negedge Rst_n) begin
    if (!Rst_n) begin
      run_q       <= 1'b0;
      presc_q     <= '0;
      slot_q      <= '0;
      div_act_q   <= '0;
      slot_1h_q   <= '0;
      slot_pls_q  <= '0;
      frame_pls_q <= 1'b0;
      ph_q        <= '0;
    end else begin
      run_q       <= run_d;
      presc_q     <= presc_d;
      slot_q      <= slot_d;
      div_act_q   <= div_act_d;
      slot_1h_q   <= slot_1h_d;
      slot_pls_q  <= slot_pls_d;
      frame_pls_q <= frame_pls_d;
      ph_q        <= ph_d;
    end
  end

  assign bus.Div_act   = div_act_q;
  assign bus.Slot_1h   = slot_1h_q;
  assign bus.Slot_pls  = slot_pls_q;
  assign bus.Frame_pls = frame_pls_q;
  assign bus.Ph_out    = ph_q;
endmodule

// File: tb/tb_motor_slot_timer.sv
// Randomized bench for motor_slot_timer against a frame-position model.
// Model derives slot/offset from elapsed cycles within the frame.
module tb_motor_slot_timer;
  localparam int CH_NUM = 8;
  localparam int PH_NUM = 2;
  localparam int DIV_W  = 16;
  localparam int GROUP  = CH_NUM / PH_NUM;

  logic gClk;
  logic Rst_n;
  int   n_tests;
  int   n_fail;

  motor_slot_timer_if #(.CH_NUM(CH_NUM), .PH_NUM(PH_NUM), .DIV_W(DIV_W)) bus ();

  motor_slot_timer #(.CH_NUM(CH_NUM), .PH_NUM(PH_NUM), .DIV_W(DIV_W)) dut (
    .gClk  (gClk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial gClk = 1'b0;
  always #5 gClk = ~gClk;

  // model: running flag, cycles since frame start, frame divisor
  bit m_run;
  int m_pos;
  int m_div;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic en, input int div);
    if (!en) begin
      m_run = 1'b0;
      m_pos = 0;
      m_div = div;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_pos = 0;
      m_div = div;
    end else begin
      m_pos++;
      if (m_pos == CH_NUM * (m_div + 1)) begin
        m_pos = 0;
        m_div = div;
      end
    end
  endtask

  task automatic compare();
    int slot;
    int off;
    logic [CH_NUM-1:0] e_1h;
    logic [CH_NUM-1:0] e_pls;
    logic [PH_NUM-1:0] e_ph;
    logic e_fr;
    e_1h  = '0;
    e_pls = '0;
    e_ph  = '0;
    e_fr  = 1'b0;
    if (m_run) begin
      slot = m_pos / (m_div + 1);
      off  = m_pos % (m_div + 1);
      e_1h = CH_NUM'(1) << slot;
      if (off == 0) e_pls = e_1h;
      e_fr = (off == 0) && (slot == 0);
      for (int k = 0; k < PH_NUM; k++)
        e_ph[k] = (slot / GROUP == k) && (slot % GROUP >= GROUP / 2);
`ifdef SLOT_GUARD_EN
      if (m_div > 0 && off == m_div) begin
        e_1h = '0;
        e_ph = '0;
      end
`else
`endif
    end
    chk("div_act", 64'(bus.Div_act), 64'(m_div));
    chk("slot_1h", 64'(bus.Slot_1h), 64'(e_1h));
    chk("slot_pls", 64'(bus.Slot_pls), 64'(e_pls));
    chk("frame_pls", 64'(bus.Frame_pls), 64'(e_fr));
    chk("ph_out", 64'(bus.Ph_out), 64'(e_ph));
  endtask

  task automatic step();
    @(posedge gClk);
    if (Rst_n) model_edge(bus.En, int'(bus.Div));
    @(negedge gClk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_run   = 1'b0;
    m_pos   = 0;
    m_div   = 0;
    Rst_n   = 1'b0;
    bus.En  = 1'b0;
    bus.Div = 16'd3;
    run(3);

    @(negedge gClk);
    Rst_n = 1'b1;
    bus.En = 1'b1;
    run(80);

    bus.En = 1'b0;
    bus.Div = 16'd0;
    run(2);
    bus.En = 1'b1;
    run(40);

    // Div=3, then change to 1 mid-frame
    bus.En = 1'b0;
    bus.Div = 16'd3;
    run(2);
    bus.En = 1'b1;
    run(18);
    bus.Div = 16'd1;
    run(40);

    // drop En mid-frame, re-raise after 3 cycles
    bus.Div = 16'd3;
    run(40);
    bus.En = 1'b0;
    run(3);
    bus.Div = 16'd2;
    bus.En = 1'b1;
    run(30);

    // asynchronous reset between edges
    #2;
    Rst_n = 1'b0;
    m_run = 1'b0;
    m_pos = 0;
    m_div = 0;
    #1;
    compare();
    @(negedge gClk);
    run(2);
    Rst_n = 1'b1;
    run(40);

    // random segments with Div changes and En drops
    for (int seg = 0; seg < 60; seg++) begin
      bus.Div = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) bus.En = 1'b0;
      else bus.En = 1'b1;
      run($urandom_range(1, 50));
    end

    // all-ones divisor: slot 0 spans 2^16 cycles
    bus.En = 1'b0;
    bus.Div = 16'hFFFF;
    run(2);
    bus.En = 1'b1;
    run(65536 + 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/motor_slot_timer.md
Name: motor_slot_timer

Overview:
- Parametrised successor to the fixed 8-slot clock divider in the motor-control datapath.
- Generates a runtime-programmable slot tick, CH_NUM one-hot time slots, per-slot start pulses, a frame pulse and PH_NUM non-overlapping phase windows.
- Sits between the board clock and the per-motor step/PWM channels, which use it to time-multiplex shared resources.

Parameters:
- CH_NUM, 8: number of time slots per frame, ≥2.
- PH_NUM, 2: number of phase outputs. CH_NUM must be divisible by PH_NUM; GROUP = CH_NUM/PH_NUM must be even and ≥2.
- DIV_W, 16: width of the slot-length divisor.

Ports:
- gClk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- En  in  1  run enable; low = idle and clear
- Div  in  DIV_W  slot length minus 1, in gClk cycles
- Div_act  out  DIV_W  divisor currently in use
- Slot_1h  out  CH_NUM  one-hot current slot, held for the whole slot
- Slot_pls  out  CH_NUM  1-cycle pulse on the first cycle of each slot
- Frame_pls  out  1  1-cycle pulse on the first cycle of slot 0
- Ph_out  out  PH_NUM  phase windows

Behaviour:
- Interface: one clock, gClk. Reset Rst_n is asynchronous, active-low.
- Reset values: all outputs 0; prescaler 0; slot counter 0; Div_act 0; run flag 0.
- Idle (En=0):
  - Prescaler and slot counter held at 0; run flag cleared.
  - Slot_1h, Slot_pls, Frame_pls and Ph_out are all 0.
  - Div_act <= Div every cycle.
- Start: on the first edge where En=1 and the run flag is 0:
  - Run flag sets; slot 0 begins.
  - Registered outputs show Slot_1h=1<<0, Slot_pls[0]=1 and Frame_pls=1 in the cycle after that edge.
- Prescaler: counts 0..Div_act. A tick occurs when it equals Div_act; on a tick it returns to 0. Div_act=0 gives a tick every cycle.
- Slot counter: advances on each tick and wraps from CH_NUM-1 to 0.
- Slot length: each slot lasts exactly Div_act+1 cycles; a frame lasts CH_NUM*(Div_act+1) cycles.
- Divisor reload while running: Div is sampled into Div_act only on the tick ending slot CH_NUM-1. A mid-frame Div change never alters the current frame.
- Slot_1h: exactly one bit high while running. The bit changes on the same edge the slot counter advances.
- Slot_pls[s]: high only on the first cycle of slot s.
  - With Div_act=0, Slot_pls equals Slot_1h.
- Frame_pls: equals Slot_pls[0].
- Ph_out[k]: high while the slot index lies in [k*GROUP+GROUP/2, (k+1)*GROUP-1]; otherwise 0.
  - Default parameters give Ph_out[0] in slots 2-3 and Ph_out[1] in slots 6-7.
  - Phases never overlap.
- En deasserted mid-frame: on the next edge all outputs go to 0 and counters return to 0. Re-enabling restarts at slot 0 with Frame_pls; there is no resume.
- Rst_n mid-operation: all state and outputs cleared immediately, independent of the clock.
- Width rules:
  - Prescaler is DIV_W bits; slot counter is ceil(log2(CH_NUM)) bits.
  - Div = all-ones is legal: slot = 2^DIV_W cycles, with no overflow beyond the compare.
- Glitch-free outputs: all outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SLOT_GUARD_EN.
- When defined, guard band active when Div_act ≥1:
  - Slot_1h is forced low on the last cycle of every slot (prescaler == Div_act).
  - This gives one dead cycle between adjacent slots.
  - Ph_out follows the same masking.
  - Slot_pls and Frame_pls are unaffected.
- Guard with Div_act=0: no guard; behaviour is identical to the undefined case.
- When undefined, Slot_1h is contiguous across slot boundaries.

Test Plan:
- Reset then En=1, Div=3 -> Frame_pls=1 on cycle 1 and every 32 cycles; Slot_1h steps 0x01,0x02,…,0x80, 4 cycles each; Slot_pls 1 cycle each.
- Div=0, En=1 -> Slot_1h rotates one bit per cycle; Slot_pls==Slot_1h; Ph_out[0] high in slots 2-3, Ph_out[1] high in slots 6-7.
- Running at Div=3, change Div to 1 during slot 4 -> slots 4-7 stay 4 cycles; next frame slots are 2 cycles; Div_act becomes 1 on the frame-boundary tick.
- Running, drop En during slot 5, re-raise after 3 cycles -> outputs 0 one edge after the drop; restart at slot 0 with Frame_pls; Div_act equals the current Div.
- Assert Rst_n=0 asynchronously mid-slot with no clock edge -> all outputs 0 immediately; on release with En=1, a clean start at slot 0.
- With SLOT_GUARD_EN, Div=3 -> Slot_1h high 3 of every 4 cycles with 1 dead cycle between slots; with Div=0, identical to the non-guard result.
